// File: rtl/fc_output_collector_if.sv
// Handshake bundle between the last FC layer, the frame collector and the max_func stage.
// master: word source and downstream completion; slave: the collector itself.
interface fc_output_collector_if #(
  parameter int NUMINPUT   = 10,
  parameter int INPUTWIDTH = 16,
  parameter int IDXWIDTH   = $clog2(NUMINPUT)
);
  logic [INPUTWIDTH-1:0]          in_data;
  logic [IDXWIDTH-1:0]            in_idx;
  logic                           in_valid;
  logic                           in_ready;
  logic [NUMINPUT*INPUTWIDTH-1:0] op_data;
  logic                           op_data_valid;
  logic                           down_done;
  logic                           busy;
  logic                           frame_err;

  modport master (
    output in_data, in_idx, in_valid, down_done,
    input  in_ready, op_data, op_data_valid, busy, frame_err
  );

  modport slave (
    input  in_data, in_idx, in_valid, down_done,
    output in_ready, op_data, op_data_valid, busy, frame_err
  );
endinterface

// File: rtl/fc_output_collector.sv
// Packs NUMINPUT neuron words into one frame for max_func and waits for its completion.
// Optional COLLECT_IDX_CHECK_EN: drop the frame and pulse frame_err when in_idx != slot count.
module fc_output_collector #(
  parameter int NUMINPUT   = 10,
  parameter int INPUTWIDTH = 16,
  parameter int IDXWIDTH   = $clog2(NUMINPUT)
) (
  input logic                  clk,
  input logic                  rst_n,
  fc_output_collector_if.slave bus
);
  localparam int                  FRAMEWIDTH = NUMINPUT * INPUTWIDTH;
  localparam logic [IDXWIDTH-1:0] LAST_IDX   = IDXWIDTH'(NUMINPUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COLLECT   = 2'd1,
    ST_ISSUE     = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_e;

  state_e                r_state;
  logic [IDXWIDTH-1:0]   r_cnt;
  logic [FRAMEWIDTH-1:0] r_buf;
  logic [FRAMEWIDTH-1:0] r_op_data;
  logic                  r_in_ready;
  logic                  r_op_data_valid;
  logic                  r_busy;
  logic                  r_frame_err;
  logic                  w_accept;
  logic                  w_idx_ok;
  logic [FRAMEWIDTH-1:0] w_buf_next;

  assign w_accept = bus.in_valid && r_in_ready;

`ifdef COLLECT_IDX_CHECK_EN
  assign w_idx_ok = (bus.in_idx == r_cnt);
`else
  logic w_unused_idx;
  assign w_unused_idx = ^bus.in_idx;
  assign w_idx_ok     = 1'b1;
`endif

  // Frame buffer with the incoming word dropped into slot r_cnt
  always_comb begin
    w_buf_next = r_buf;
    for (int k = 0; k < NUMINPUT; k++) begin
      if (r_cnt == IDXWIDTH'(k)) begin
        w_buf_next[k*INPUTWIDTH +: INPUTWIDTH] = bus.in_data;
      end else begin
        w_buf_next[k*INPUTWIDTH +: INPUTWIDTH] = r_buf[k*INPUTWIDTH +: INPUTWIDTH];
      end
    end
  end

  // Collector FSM; the issue edge loads op_data directly so the pulse and data coincide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_cnt           <= '0;
      r_buf           <= '0;
      r_op_data       <= '0;
      r_in_ready      <= 1'b0;
      r_op_data_valid <= 1'b0;
      r_busy          <= 1'b0;
      r_frame_err     <= 1'b0;
    end else begin
      r_op_data_valid <= 1'b0;
      r_frame_err     <= 1'b0;
      case (r_state)
        ST_IDLE, ST_COLLECT: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            if (!w_idx_ok) begin
              r_buf       <= '0;
              r_cnt       <= '0;
              r_state     <= ST_IDLE;
              r_frame_err <= 1'b1;
            end else if (r_cnt == LAST_IDX) begin
              r_buf           <= w_buf_next;
              r_op_data       <= w_buf_next;
              r_op_data_valid <= 1'b1;
              r_in_ready      <= 1'b0;
              r_busy          <= 1'b1;
              r_cnt           <= '0;
              r_state         <= ST_ISSUE;
            end else begin
              r_buf   <= w_buf_next;
              r_cnt   <= r_cnt + IDXWIDTH'(1);
              r_state <= ST_COLLECT;
            end
          end
        end
        ST_ISSUE: begin
          r_in_ready <= 1'b0;
          r_busy     <= 1'b1;
          r_state    <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (bus.down_done) begin
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= ST_IDLE;
          end else begin
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_cnt      <= '0;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready      = r_in_ready;
  assign bus.op_data       = r_op_data;
  assign bus.op_data_valid = r_op_data_valid;
  assign bus.busy          = r_busy;
  assign bus.frame_err     = r_frame_err;
endmodule

// File: tb/tb_fc_output_collector.sv
// Self-checking bench for fc_output_collector: randomized frames against a packing model.
module tb_fc_output_collector;
  localparam int NI = 10;
  localparam int IW = 16;
  localparam int XW = $clog2(NI);
  localparam int FW = NI * IW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulses = 0;
  int last_pulse_cyc = -1;
  int ferr_cnt = 0;
  logic [FW-1:0] prev_frame;

  fc_output_collector_if #(.NUMINPUT(NI), .INPUTWIDTH(IW), .IDXWIDTH(XW)) bus ();

  fc_output_collector #(.NUMINPUT(NI), .INPUTWIDTH(IW), .IDXWIDTH(XW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Edge counter plus pulse bookkeeping for op_data_valid and frame_err
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.op_data_valid === 1'b1) begin
      pulses         <= pulses + 1;
      last_pulse_cyc <= cyc;
    end
    if (bus.frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
  end

  // Reference: word k lands k*IW bits up, first word in the LSBs
  function automatic logic [FW-1:0] model_frame(input logic [IW-1:0] w[NI]);
    logic [FW-1:0] f;
    f = '0;
    for (int k = NI - 1; k >= 0; k--) f = (f << IW) | FW'(w[k]);
    return f;
  endfunction

  task automatic put_word(input logic [IW-1:0] d, input logic [XW-1:0] x, output int acc);
    int waited;
    waited = 0;
    bus.in_data  = d;
    bus.in_idx   = x;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (waited >= 100) begin
      errors++;
      $display("FAIL accept_timeout in_ready=%b required=1", bus.in_ready);
    end
    @(posedge clk);
    acc = cyc;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [IW-1:0] w[NI], input logic [XW-1:0] x[NI],
                            input int gap_lo, input int gap_hi, input bit noise, output int acc);
    int g;
    for (int k = 0; k < NI; k++) begin
      put_word(w[k], x[k], acc);
      if (k < NI - 1) begin
        g = $urandom_range(gap_hi, gap_lo);
        if (g > 0 && noise) bus.down_done = 1'b1;
        repeat (g) @(negedge clk);
        bus.down_done = 1'b0;
      end
    end
  endtask

  task automatic pulse_done();
    bus.down_done = 1'b1;
    @(negedge clk);
    bus.down_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.op_data !== '0 || bus.op_data_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.frame_err !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got data=%h v=%b busy=%b ferr=%b rdy=%b required all 0",
               bus.op_data, bus.op_data_valid, bus.busy, bus.frame_err, bus.in_ready);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got rdy=%b busy=%b required rdy=1 busy=0", bus.in_ready, bus.busy);
    end
    @(negedge clk);
  endtask

  task automatic test_full_frame();
    logic [IW-1:0] w[NI];
    logic [XW-1:0] x[NI];
    logic [FW-1:0] exp;
    int acc, p0;
    for (int k = 0; k < NI; k++) begin
      w[k] = IW'(k + 1);
      x[k] = XW'(k);
    end
    exp = model_frame(w);
    p0  = pulses;
    send_frame(w, x, 0, 0, 1'b0, acc);
    checks++;
    if (bus.op_data_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL full_issue got v=%b rdy=%b busy=%b required 1 0 1",
               bus.op_data_valid, bus.in_ready, bus.busy);
    end
    checks++;
    if (bus.op_data !== exp) begin
      errors++;
      $display("FAIL full_data got %h required %h", bus.op_data, exp);
    end
    checks++;
    if (bus.op_data[15:0] !== 16'h0001 || bus.op_data[159:144] !== 16'h000A) begin
      errors++;
      $display("FAIL full_ends got lo=%h hi=%h required 0001 000a", bus.op_data[15:0], bus.op_data[159:144]);
    end
    @(negedge clk);
    checks++;
    if (bus.op_data_valid !== 1'b0 || bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_wait got v=%b busy=%b rdy=%b required 0 1 0",
               bus.op_data_valid, bus.busy, bus.in_ready);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (pulses - p0 !== 1 || last_pulse_cyc !== acc + 1) begin
      errors++;
      $display("FAIL full_pulse got count=%0d at=%0d required 1 at %0d", pulses - p0, last_pulse_cyc, acc + 1);
    end
    prev_frame = exp;
  endtask

  task automatic test_backpressure();
    logic [IW-1:0] w[NI];
    logic [FW-1:0] exp;
    int acc, p0;
    bit seen_ready;
    p0 = pulses;
    seen_ready = 1'b0;
    bus.in_data  = 16'h1234;
    bus.in_idx   = '0;
    bus.in_valid = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) seen_ready = 1'b1;
    end
    checks++;
    if (seen_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_no_accept got ready_seen=%b required 0", seen_ready);
    end
    pulse_done();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.op_data !== prev_frame) begin
      errors++;
      $display("FAIL bp_after_done got rdy=%b busy=%b data=%h required 1 0 %h",
               bus.in_ready, bus.busy, bus.op_data, prev_frame);
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    w[0] = 16'h1234;
    for (int k = 1; k < NI; k++) begin
      w[k] = IW'($urandom);
      put_word(w[k], XW'(k), acc);
      if (k == 5) begin
        checks++;
        if (bus.op_data !== prev_frame || bus.op_data_valid !== 1'b0) begin
          errors++;
          $display("FAIL bp_hold got %h v=%b required %h v=0", bus.op_data, bus.op_data_valid, prev_frame);
        end
      end
    end
    exp = model_frame(w);
    checks++;
    if (bus.op_data !== exp || bus.op_data[15:0] !== 16'h1234 || bus.op_data_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_frame got %h v=%b required %h v=1", bus.op_data, bus.op_data_valid, exp);
    end
    @(negedge clk);
    checks++;
    if (pulses - p0 !== 1) begin
      errors++;
      $display("FAIL bp_pulse_count got %0d required 1", pulses - p0);
    end
    prev_frame = exp;
    pulse_done();
  endtask

  task automatic test_gapped();
    logic [IW-1:0] w[NI];
    logic [XW-1:0] x[NI];
    logic [FW-1:0] exp;
    int acc, p0;
    for (int k = 0; k < NI; k++) begin
      w[k] = IW'(k + 1);
      x[k] = XW'(k);
    end
    exp = model_frame(w);
    p0  = pulses;
    send_frame(w, x, 3, 3, 1'b1, acc);
    checks++;
    if (bus.op_data !== exp || bus.op_data_valid !== 1'b1) begin
      errors++;
      $display("FAIL gap_frame got %h v=%b required %h v=1", bus.op_data, bus.op_data_valid, exp);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (pulses - p0 !== 1 || last_pulse_cyc !== acc + 1) begin
      errors++;
      $display("FAIL gap_pulse got count=%0d at=%0d required 1 at %0d", pulses - p0, last_pulse_cyc, acc + 1);
    end
    pulse_done();
  endtask

  task automatic test_idx_check();
    logic [IW-1:0] w[NI];
    logic [XW-1:0] x[NI];
    logic [FW-1:0] exp;
    int acc, p0, f0, first_bad;
    x[0] = 4'd0; x[1] = 4'd1; x[2] = 4'd2; x[3] = 4'd5;
    for (int k = 4; k < NI; k++) x[k] = XW'(k);
    for (int k = 0; k < NI; k++) w[k] = IW'($urandom);
    first_bad = NI;
    for (int k = NI - 1; k >= 0; k--) if (x[k] != XW'(k)) first_bad = k;
    p0 = pulses;
    f0 = ferr_cnt;
`ifdef COLLECT_IDX_CHECK_EN
    for (int k = 0; k <= first_bad; k++) put_word(w[k], x[k], acc);
    checks++;
    if (bus.frame_err !== 1'b1 || bus.op_data_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL idx_err got ferr=%b v=%b rdy=%b busy=%b required 1 0 1 0",
               bus.frame_err, bus.op_data_valid, bus.in_ready, bus.busy);
    end
    @(negedge clk);
    checks++;
    if (bus.frame_err !== 1'b0 || bus.op_data !== prev_frame) begin
      errors++;
      $display("FAIL idx_err_clear got ferr=%b data=%h required 0 %h", bus.frame_err, bus.op_data, prev_frame);
    end
    for (int k = 0; k < NI; k++) x[k] = XW'(k);
    send_frame(w, x, 0, 1, 1'b0, acc);
    exp = model_frame(w);
    checks++;
    if (bus.op_data !== exp || bus.op_data_valid !== 1'b1) begin
      errors++;
      $display("FAIL idx_recover got %h v=%b required %h v=1", bus.op_data, bus.op_data_valid, exp);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (pulses - p0 !== 1 || ferr_cnt - f0 !== 1) begin
      errors++;
      $display("FAIL idx_counts got pulses=%0d ferr=%0d required 1 1", pulses - p0, ferr_cnt - f0);
    end
`else
    send_frame(w, x, 0, 1, 1'b0, acc);
    exp = model_frame(w);
    checks++;
    if (bus.op_data !== exp || bus.op_data_valid !== 1'b1) begin
      errors++;
      $display("FAIL idx_ignored got %h v=%b required %h v=1", bus.op_data, bus.op_data_valid, exp);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (pulses - p0 !== 1 || ferr_cnt - f0 !== 0 || first_bad !== 3) begin
      errors++;
      $display("FAIL idx_counts got pulses=%0d ferr=%0d bad=%0d required 1 0 3", pulses - p0, ferr_cnt - f0, first_bad);
    end
`endif
    prev_frame = exp;
    pulse_done();
  endtask

  task automatic test_mid_reset();
    logic [IW-1:0] w[NI];
    logic [XW-1:0] x[NI];
    logic [FW-1:0] exp;
    int acc;
    for (int k = 0; k < 5; k++) put_word(IW'($urandom), XW'(k), acc);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.op_data !== '0 || bus.in_ready !== 1'b0 || bus.busy !== 1'b0 || bus.op_data_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_clear got data=%h rdy=%b busy=%b v=%b required all 0",
               bus.op_data, bus.in_ready, bus.busy, bus.op_data_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < NI; k++) begin
      w[k] = IW'(16'h00A0 + k);
      x[k] = XW'(k);
    end
    send_frame(w, x, 0, 0, 1'b0, acc);
    exp = model_frame(w);
    checks++;
    if (bus.op_data !== exp || bus.op_data[15:0] !== 16'h00A0 || bus.op_data_valid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_frame got %h v=%b required %h v=1", bus.op_data, bus.op_data_valid, exp);
    end
    prev_frame = exp;
    @(negedge clk);
    pulse_done();
  endtask

  task automatic test_back_to_back();
    logic [IW-1:0] w[NI];
    logic [XW-1:0] x[NI];
    logic [FW-1:0] exp;
    int acc, p0;
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < NI; k++) begin
        w[k] = IW'($urandom);
        x[k] = XW'(k);
      end
      exp = model_frame(w);
      p0  = pulses;
      send_frame(w, x, 0, 2, 1'b1, acc);
      checks++;
      if (bus.op_data !== exp || bus.op_data_valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b_frame%0d got %h v=%b required %h v=1", f, bus.op_data, bus.op_data_valid, exp);
      end
      repeat ($urandom_range(4, 1)) @(negedge clk);
      checks++;
      if (pulses - p0 !== 1 || last_pulse_cyc !== acc + 1 || bus.op_data !== exp) begin
        errors++;
        $display("FAIL b2b_pulse%0d got count=%0d at=%0d required 1 at %0d", f, pulses - p0, last_pulse_cyc, acc + 1);
      end
      pulse_done();
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready%0d got %b required 1", f, bus.in_ready);
      end
    end
  endtask

  initial begin
    bus.in_data   = '0;
    bus.in_idx    = '0;
    bus.in_valid  = 1'b0;
    bus.down_done = 1'b0;
    prev_frame    = '0;
    test_reset();
    test_full_frame();
    test_backpressure();
    test_gapped();
    test_idx_check();
    test_mid_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fc_output_collector.md
# fc_output_collector

Serial-to-parallel frame collector feeding the `max_func` classification stage of the CNN. It accepts the final fully connected layer's neuron outputs one word per handshake and packs `NUMINPUT` words into a single vector. It issues that vector to `max_func` with a one-cycle valid pulse, then holds off new input until `max_func` reports completion.

## Interface

**Parameters**
- `NUMINPUT`, 10: neurons per frame, i.e. words packed per output vector.
- `INPUTWIDTH`, 16: width of one neuron output word.
- `IDXWIDTH`, `$clog2(NUMINPUT)`: width of the neuron index field.

**Ports** (one clock; reset asynchronous, active-low)
- `clk` in 1: clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `in_data` in `INPUTWIDTH`: neuron output word.
- `in_idx` in `IDXWIDTH`: neuron index of `in_data`.
- `in_valid` in 1: `in_data`/`in_idx` valid.
- `in_ready` out 1: collector can accept; a transfer occurs when `in_valid && in_ready`.
- `op_data` out `NUMINPUT*INPUTWIDTH`: packed frame, connects to `max_func.ip_data`.
- `op_data_valid` out 1: one-cycle issue pulse, connects to `max_func.ip_valid`.
- `down_done` in 1: completion from downstream, connects to `max_func.op_data_valid`.
- `busy` out 1: high in ISSUE and WAIT_DONE.
- `frame_err` out 1: one-cycle index-mismatch pulse; tied 0 without `COLLECT_IDX_CHECK_EN`.

## Operation

**States**
- IDLE: `cnt==0`, `in_ready=1`. The first accept writes slot 0 and moves to COLLECT.
- COLLECT: `in_ready=1`. Each accept writes `buf[cnt]` and increments `cnt`. The accept with `cnt==NUMINPUT-1` moves to ISSUE.
- ISSUE: lasts exactly one cycle.
  - `buf` is copied to `op_data`, `op_data_valid=1`, `in_ready=0`, `cnt` cleared.
  - Unconditionally moves to WAIT_DONE.
- WAIT_DONE: `in_ready=0`. Moves to IDLE when `down_done` is sampled high.

**Data rules**
- Packing: the word received k-th (k=0..`NUMINPUT`-1) occupies `op_data[k*INPUTWIDTH +: INPUTWIDTH]`. The first word goes in the LSBs.
- Buffering: `buf` and `op_data` are separate registers. `op_data` changes only in the ISSUE update, so it is stable from issue until the next frame's issue, including while the next frame is collected.
- Words are stored unmodified; there is no arithmetic.

**Boundary conditions**
- `down_done` is ignored in IDLE, COLLECT and ISSUE.
- `in_valid` without `in_ready` leaves no state change; the word must be held by the source.
- `in_valid` gaps mid-frame stall `cnt`. There is no timeout.
- `cnt` never exceeds `NUMINPUT-1`. There is no wrap into a partial next frame.

**Reset**
- Asserting `rst_n` low at any time discards any partial frame.
- While `rst_n` is low:
  - State is IDLE and `cnt=0`.
  - `buf`, `op_data`, `op_data_valid`, `frame_err` and `busy` are all 0.
  - `in_ready` is 0.
- After release, `in_ready=1` from the first rising edge.

## Timing

- Accept happens at rising edge T for a word presented in cycle T-1 with `in_ready=1`.
- Last-word accept at edge T gives ISSUE in cycle T..T+1: `op_data` updated and `op_data_valid=1`.
- `in_ready` falls in the same cycle as the issue pulse.
- Issue latency is `NUMINPUT` accepts plus 1 cycle. Minimum frame period is `NUMINPUT`+2+downstream latency.
- `down_done` sampled high at edge D makes `in_ready=1` in the cycle after D. A word can then be accepted at edge D+1.
- `op_data_valid` and `frame_err` are registered outputs, never combinational from inputs.

## Configuration

Macro: `COLLECT_IDX_CHECK_EN`.

**Defined**
- Every accepted word's `in_idx` is compared with `cnt`.
- On mismatch:
  - The word is dropped.
  - `buf` contents are discarded and `cnt` is cleared.
  - State becomes IDLE.
  - `frame_err` pulses high for one cycle after the accepting edge.
  - No issue occurs for that frame.

**Undefined**
- `in_idx` is ignored.
- `frame_err` is constant 0.

## Test plan

- Reset: hold `rst_n=0`, check all outputs are 0. Release, check `in_ready=1` on the next edge.
- Full frame: send words 0x0001..0x000A with idx 0..9 back-to-back. Check:
  - exactly one `op_data_valid` pulse, one cycle after the 10th accept;
  - `op_data[15:0]=0x0001` and `op_data[159:144]=0x000A`;
  - `in_ready=0` and `busy=1`.
- Backpressure: hold `in_valid=1` with 0x1234/idx 0 during WAIT_DONE, then pulse `down_done` after 20 cycles. Check:
  - no accept before the pulse;
  - `in_ready=1` one cycle after the pulse;
  - 0x1234 lands in slot 0;
  - previous `op_data` is unchanged until the next issue.
- Gapped input: a frame with 3-cycle `in_valid` gaps gives the same `op_data` as the back-to-back frame, issued one cycle after the last accept.
- Index check: send idx 0,1,2,5.
  - With the macro: `frame_err` pulses after the 4th accept, with no issue. A following correct frame issues correctly.
  - Without the macro: the 10-word frame issues normally and `frame_err` stays 0.
- Mid-frame reset: assert `rst_n` low after 5 words. Check `op_data` clears to 0. A subsequent 10-word frame 0xA0..0xA9 issues with 0xA0 in bits [15:0].
